// File: rtl/wide_add_pkg.sv
// Shared definitions for the byte-serial wide adder/subtractor.
//   DEF_WIDTH / DEF_WORDS : default slice width and slice count
//   ST_*                  : state encoding of the sequencing FSM
//   state_t               : enumerated state type built on that encoding
package wide_add_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_WORDS = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/wide_add_seq_bit8_adder.sv
// Narrow combinational adder used once per slice by wide_add_seq.
//   a, b : WIDTH-bit slice operands
//   cin  : carry into the slice
//   sum  : WIDTH-bit slice sum
//   cout : carry out of the slice (the sum's bit WIDTH)
module bit8_adder
    import wide_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    end

endmodule

// File: rtl/wide_add_seq.sv
// Byte-serial multi-word adder/subtractor controller.
// Takes two WIDTH*WORDS-bit operands over a valid/ready handshake, pushes them
// LSB slice first through one shared bit8_adder while chaining the carry, and
// returns the wide result with carry and signed overflow over a second
// valid/ready handshake.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : request handshake
//   op_a, op_b, cin, sub : operands, carry/borrow in, 0=add 1=subtract
//   out_valid/out_ready  : result handshake
//   result, cout         : wide sum/difference, final carry (borrow = ~cout)
//   overflow             : two's-complement overflow of the full-width op
//   busy                 : high while running or holding a result
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// RUN   | one slice per cycle through the adder, LSB first
// DONE  | result presented, held until out_ready
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int WORDS = DEF_WORDS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*WORDS-1:0] op_a,
    input  logic [WIDTH*WORDS-1:0] op_b,
    input  logic                   cin,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*WORDS-1:0] result,
    output logic                   cout,
    output logic                   overflow,
    output logic                   busy
);

    localparam int N     = WIDTH * WORDS;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

    state_t           state_q, state_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N-1:0]     result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] slice_a;
    logic [WIDTH-1:0] slice_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    assign slice_a = a_q[idx_q*WIDTH +: WIDTH];
    assign slice_b = b_q[idx_q*WIDTH +: WIDTH];

    bit8_adder #(.WIDTH(WIDTH)) u_bit8_adder (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        result_d    = result_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    // Subtraction is A + ~B + ~borrow_in, so B is inverted here
                    // and the carry seed becomes cin^sub.
                    a_d        = op_a;
                    b_d        = sub ? ~op_b : op_b;
                    carry_d    = cin ^ sub;
                    idx_d      = '0;
                    state_d    = S_RUN;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            S_RUN: begin
                result_d[idx_q*WIDTH +: WIDTH] = add_sum;
                carry_d = add_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) begin
                    cout_d      = add_cout;
                    // b_q already carries the inversion for subtract, so the
                    // plain same-sign-in / different-sign-out rule applies.
                    ovf_d       = (a_q[N-1] == b_q[N-1]) && (add_sum[WIDTH-1] != a_q[N-1]);
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                end
            end
            S_DONE: begin
                // A request arriving alongside out_ready is not taken here;
                // in_ready only rises once back in IDLE.
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            result_q    <= result_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result    = result_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Randomized and directed bench for wide_add_seq (WIDTH=8, WORDS=4).
module tb_wide_add_seq;

    localparam int WIDTH = 8;
    localparam int WORDS = 4;
    localparam int N     = WIDTH * WORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         cout;
    logic         overflow;
    logic         busy;

    always #5 clk = ~clk;

    wide_add_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow),
        .busy      (busy)
    );

    typedef struct packed {
        logic [N-1:0] res;
        logic         co;
        logic         ov;
    } exp_t;

    exp_t         sb[$];
    int           checks   = 0;
    int           failures = 0;
    logic [N-1:0] prev_res = '0;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference: plain wide arithmetic on whole operands, signed range test for overflow.
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                   input logic c, input logic s);
        exp_t        e;
        logic [N:0]  w;
        longint      sv;
        longint      lim;
        lim = longint'(1) <<< (N - 1);
        if (s) begin
            w    = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, c};
            e.co = ~w[N];
            sv   = longint'($signed(a)) - longint'($signed(b)) - longint'(c);
        end else begin
            w    = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
            e.co = w[N];
            sv   = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
        end
        e.res = w[N-1:0];
        e.ov  = (sv >= lim) || (sv < -lim);
        return e;
    endfunction

    // Expected result register after n slices of a new op have been written.
    function automatic logic [N-1:0] mix(input logic [N-1:0] old_r, input logic [N-1:0] new_r, input int n);
        logic [N-1:0] r;
        for (int k = 0; k < WORDS; k++)
            r[k*WIDTH +: WIDTH] = (k < n) ? new_r[k*WIDTH +: WIDTH] : old_r[k*WIDTH +: WIDTH];
        return r;
    endfunction

    // Monitor: pops the scoreboard on every result handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=%h required=none", result);
                end else begin
                    e = sb.pop_front();
                    check("result", result, e.res);
                    check("cout", N'(cout), N'(e.co));
                    check("overflow", N'(overflow), N'(e.ov));
                end
            end
        end
    end

    task automatic wait_ready();
        int cnt = 0;
        while (!in_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout actual=0 required=1");
        end
    endtask

    // Issues one op, checks latency, busy/in_ready and slice-by-slice fill.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c, input logic s);
        exp_t e;
        int   cnt;
        wait_ready();
        e = model(a, b, c, s);
        sb.push_back(e);
        op_a = a; op_b = b; cin = c; sub = s; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 0;
        forever begin
            #1;
            check("slice_fill", result, mix(prev_res, e.res, (cnt > WORDS) ? WORDS : cnt));
            check("busy", N'(busy), N'(1));
            check("in_ready_low", N'(in_ready), N'(0));
            if (out_valid || cnt > WORDS + 2) break;
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        check("latency", N'(cnt), N'(WORDS));
        prev_res = e.res;
    endtask

    initial begin
        logic [N-1:0] ra, rb;
        logic [N-1:0] held;
        rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        #2;
        check("rst_in_ready", N'(in_ready), N'(1));
        check("rst_out_valid", N'(out_valid), N'(0));
        check("rst_busy", N'(busy), N'(0));
        check("rst_result", result, '0);
        check("rst_flags", N'({cout, overflow}), N'(0));
        @(negedge clk);
        rst = 1'b0;

        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
        run_op(32'h00000005, 32'h00000007, 1'b0, 1'b1);
        run_op(32'h000000FF, 32'h00000001, 1'b1, 1'b0);

        // Asynchronous reset in the middle of RUN.
        wait_ready();
        op_a = 32'h12345678; op_b = 32'h11111111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_result", result, '0);
        check("arst_busy", N'(busy), N'(0));
        check("arst_out_valid", N'(out_valid), N'(0));
        check("arst_cout", N'(cout), N'(0));
        check("arst_in_ready", N'(in_ready), N'(1));
        prev_res = '0;
        @(negedge clk);
        rst = 1'b0;
        run_op(32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0);

        // Backpressure: result held, extra requests dropped.
        @(negedge clk);
        out_ready = 1'b0;
        run_op(32'h89ABCDEF, 32'h01234567, 1'b1, 1'b1);
        held = prev_res;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0);
            op_a = $urandom; op_b = $urandom;
            #1;
            check("bp_out_valid", N'(out_valid), N'(1));
            check("bp_in_ready", N'(in_ready), N'(0));
            check("bp_result", result, held);
        end
        @(negedge clk);
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("release_out_valid", N'(out_valid), N'(0));
        check("release_in_ready", N'(in_ready), N'(1));
        check("release_not_accepted", N'(busy), N'(0));

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 8 == 1) ra = {1'b0, {(N-1){1'b1}}};
            if (i % 8 == 2) rb = {1'b1, {(N-1){1'b0}}};
            run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", N'(sb.size()), N'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
